// File: rtl/wb_port_arbiter.sv
// Two-port register-file write-back arbiter with burst-limited fairness.
// Requester 1 (load) wins ties from idle; the current owner keeps the port
// until it has taken MAX_BURST consecutive grants while the other waits.
// Optional build macro: WB_ZERO_FILTER_EN (suppress wr_en for writes to r0).
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [4:0]        addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [4:0]        addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              sel,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        burst_cnt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t            state, state_nxt;
  logic [3:0]        burst_nxt;
  logic [3:0]        burst_inc;
  logic              wr_en_nxt;
  logic [4:0]        addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign burst_inc = (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;

  // Grant decision, next state and next burst count.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    burst_nxt = '0;
    // Grants are gated by reset_n so they drop the moment reset asserts.
    if (reset_n) begin
      if (req0 && req1) begin
        case (state)
          OWN0: begin
            if (burst_cnt >= BURST_LIMIT) gnt1 = 1'b1;
            else                          gnt0 = 1'b1;
          end
          OWN1: begin
            if (burst_cnt >= BURST_LIMIT) gnt0 = 1'b1;
            else                          gnt1 = 1'b1;
          end
          default: gnt1 = 1'b1;
        endcase
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    if (gnt0) begin
      state_nxt = OWN0;
      burst_nxt = (state == OWN0) ? burst_inc : 4'd1;
    end else if (gnt1) begin
      state_nxt = OWN1;
      burst_nxt = (state == OWN1) ? burst_inc : 4'd1;
    end
  end

  // Write-port mux and enable for the transfer accepted this cycle.
  always_comb begin
    addr_nxt  = gnt1 ? addr1 : addr0;
    data_nxt  = gnt1 ? data1 : data0;
    wr_en_nxt = gnt0 || gnt1;
`ifdef WB_ZERO_FILTER_EN
    if (addr_nxt == 5'd0) wr_en_nxt = 1'b0;
`endif
  end

  // Arbitration state and consecutive-grant counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Registered write-back outputs; address/data/select hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_en_nxt;
      if (gnt0 || gnt1) begin
        sel     <= gnt1;
        wr_addr <= addr_nxt;
        wr_data <= data_nxt;
      end
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the write-back data path.
REQ-002 Parameter MAX_BURST, default 4, range 1-15; consecutive grants to one requester allowed while the other waits.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port req0  input  1  requester 0 (ALU write-back) valid.
REQ-006 Port addr0  input  5  requester 0 destination register (rd).
REQ-007 Port data0  input  DATA_W  requester 0 write data.
REQ-008 Port gnt0  output  1  requester 0 accepted this cycle.
REQ-009 Port req1  input  1  requester 1 (load write-back) valid.
REQ-010 Port addr1  input  5  requester 1 destination register (rt).
REQ-011 Port data1  input  DATA_W  requester 1 write data.
REQ-012 Port gnt1  output  1  requester 1 accepted this cycle.
REQ-013 Port sel  output  1  select for the 5-bit write-address mux; 0 = addr0 path, 1 = addr1 path.
REQ-014 Port wr_en  output  1  register-file write enable.
REQ-015 Port wr_addr  output  5  register-file write address.
REQ-016 Port wr_data  output  DATA_W  register-file write data.
REQ-017 Port burst_cnt  output  4  current consecutive-grant count (debug).

Function
REQ-018 Requester N SHALL hold reqN, addrN and dataN stable until the cycle gntN is high; transfer occurs in the cycle reqN and gntN are both high.
REQ-019 gnt0/gnt1 SHALL be combinational from req0, req1 and registered state; never both high in the same cycle; gntN never high without reqN.
REQ-020 FSM states: IDLE (no grant last cycle), OWN0 (last grant to 0), OWN1 (last grant to 1).
REQ-021 Only one requester active: grant it, regardless of state.
REQ-022 Both active in IDLE: grant requester 1 (load priority).
REQ-023 Both active in OWNk: keep granting k while burst_cnt < MAX_BURST; when burst_cnt == MAX_BURST, grant the other requester.
REQ-024 burst_cnt SHALL be set to 1 on a grant to a different requester than last, incremented on a repeat grant (saturating at 15), and cleared to 0 on a cycle with no grant.
REQ-025 Next state: OWN0 on gnt0, OWN1 on gnt1, IDLE on no grant.
REQ-026 Latency: a transfer accepted in cycle T SHALL appear on sel/wr_addr/wr_data/wr_en at the rising edge ending cycle T (registered, one cycle).
REQ-027 Registered outputs for a grant to N: sel = N, wr_addr = addrN, wr_data = dataN, wr_en = 1 (subject to REQ-033).
REQ-028 Cycle without grant: wr_en = 0; sel, wr_addr, wr_data hold their previous values.
REQ-029 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, burst_cnt = 0, sel = 0, wr_en = 0, wr_addr = 0, wr_data = 0, gnt0 = gnt1 = 0.
REQ-031 Reset asserted mid-transfer SHALL discard the pending write (wr_en = 0); requesters re-present after reset.
REQ-032 After reset_n rises, the first edge SHALL behave as in IDLE.

Configuration
REQ-033 Macro WB_ZERO_FILTER_EN: when defined, a granted transfer with address 5'd0 is accepted (gnt high, FSM/counter update as normal) but the registered wr_en is 0; when undefined, address 0 writes assert wr_en = 1 like any other.

Verification
REQ-034 Reset: reset_n = 0 with req0 = req1 = 1 -> gnt0 = gnt1 = 0, wr_en = 0, wr_addr = 0, burst_cnt = 0.
REQ-035 Single requester: req0 = 1, addr0 = 5'd8, data0 = 32'hDEADBEEF for one cycle -> gnt0 = 1 that cycle; next edge sel = 0, wr_addr = 8, wr_data = 32'hDEADBEEF, wr_en = 1; following cycle wr_en = 0.
REQ-036 Simultaneous from IDLE: req0 = req1 = 1 (addr0 = 3, addr1 = 9) -> gnt1 first, then sel = 1, wr_addr = 9.
REQ-037 Burst limit: MAX_BURST = 4, req0 and req1 held high continuously -> grants 1,1,1,1,0,0,0,0,1... ; burst_cnt sequence 1,2,3,4,1,2,3,4,1.
REQ-038 Zero filter: addr1 = 0, req1 = 1 -> gnt1 = 1; wr_en = 0 with WB_ZERO_FILTER_EN, wr_en = 1 without.
REQ-039 Mid-burst reset: reset_n pulsed low during third of four back-to-back grants -> wr_en = 0 immediately, state IDLE, burst_cnt = 0; next simultaneous request grants requester 1.
